// File: rtl/i2c_master_multibyte_if.sv
// i2c_master_multibyte_if: control handshake and open-drain pad bundle for i2c_master_multibyte.
interface i2c_master_multibyte_if #(
  parameter int LEN_W = 4
);
  logic start;
  logic rw;
  logic [6:0] addr;
  logic [LEN_W-1:0] len;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic busy;
  logic done;
  logic nack_err;
  logic scl_i;
  logic scl_oe;
  logic sda_i;
  logic sda_oe;
  modport master (
    input start, rw, addr, len, tx_data, tx_valid, scl_i, sda_i,
    output tx_ready, rx_data, rx_valid, busy, done, nack_err, scl_oe, sda_oe
  );
  modport slave (
    output start, rw, addr, len, tx_data, tx_valid, scl_i, sda_i,
    input tx_ready, rx_data, rx_valid, busy, done, nack_err, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_master_multibyte.sv
// i2c_master_multibyte: single-master I2C engine for multi-byte reads/writes over open-drain pads.
// Define I2C_MASTER_CLK_STRETCH_EN to honour slave clock stretching on scl_i.
module i2c_master_multibyte #(
  parameter int CLK_DIV = 25,
  parameter int LEN_W = 4
) (
  input logic clk,
  input logic rst,
  i2c_master_multibyte_if.master bus
);
  localparam int QW = $clog2(CLK_DIV);
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, LOAD, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
  } state_t;
  state_t state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0] q;
  logic [2:0] bcnt;
  logic [LEN_W-1:0] cnt;
  logic [7:0] sh;
  logic [7:0] rx_data;
  logic rw_q, ack, done, rx_valid, nack_err;
  logic scl_low, sda_low, run, stall, tick, adv, bit_end;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign stall = !scl_low && !bus.scl_i;
`else
  logic unused_scl;
  assign unused_scl = bus.scl_i;
  assign stall = 1'b0;
`endif
  assign run = state != IDLE && state != LOAD;
  assign tick = run && !stall && qcnt == QW'(CLK_DIV - 1);
  assign adv = tick && q == 2'd3;
  assign bit_end = adv && bcnt == 3'd7;
  assign scl_low = state == LOAD || (run && state != START && !q[1]);
  assign sda_low = state == START ? q[1] :
                   (state == ADDR || state == WR_BYTE) ? !sh[7] :
                   state == RD_ACK ? cnt != '0 :
                   state == STOP && q != 2'd3;
  assign bus.scl_oe = scl_low;
  assign bus.sda_oe = sda_low;
  assign bus.busy = state != IDLE;
  assign bus.tx_ready = state == LOAD;
  assign bus.done = done;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data = rx_data;
  assign bus.nack_err = nack_err;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = bus.start ? START : IDLE;
      START:    state_n = adv ? ADDR : START;
      ADDR:     state_n = bit_end ? ADDR_ACK : ADDR;
      ADDR_ACK: state_n = !adv ? ADDR_ACK : (!ack || cnt == '0) ? STOP : rw_q ? RD_BYTE : LOAD;
      LOAD:     state_n = bus.tx_valid ? WR_BYTE : LOAD;
      WR_BYTE:  state_n = bit_end ? WR_ACK : WR_BYTE;
      WR_ACK:   state_n = !adv ? WR_ACK : (ack && cnt != '0) ? LOAD : STOP;
      RD_BYTE:  state_n = bit_end ? RD_ACK : RD_BYTE;
      RD_ACK:   state_n = !adv ? RD_ACK : cnt != '0 ? RD_BYTE : STOP;
      STOP:     state_n = adv ? IDLE : STOP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      qcnt <= '0;
      q <= '0;
      bcnt <= '0;
      cnt <= '0;
      sh <= '0;
      rw_q <= 1'b0;
      ack <= 1'b0;
      done <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      nack_err <= 1'b0;
    end else begin
      state <= state_n;
      qcnt <= (!run || tick || stall) ? '0 : qcnt + 1'b1;
      if (tick) q <= q + 1'b1;
      done <= state == STOP && adv;
      rx_valid <= 1'b0;
      if (state == IDLE && bus.start) begin
        sh <= {bus.addr, bus.rw};
        rw_q <= bus.rw;
        cnt <= bus.len;
        nack_err <= 1'b0;
        q <= '0;
        bcnt <= '0;
      end
      if (state == LOAD && bus.tx_valid) sh <= bus.tx_data;
      // SDA is sampled at the end of Q2, while SCL is high
      if (tick && q == 2'd2) begin
        ack <= !bus.sda_i;
        if (state == RD_BYTE) begin
          sh <= {sh[6:0], bus.sda_i};
          if (bcnt == 3'd7) begin
            rx_data <= {sh[6:0], bus.sda_i};
            rx_valid <= 1'b1;
            cnt <= cnt - 1'b1;
          end
        end
      end
      if (adv) begin
        if (state == ADDR || state == WR_BYTE) sh <= {sh[6:0], 1'b0};
        if (state == ADDR || state == WR_BYTE || state == RD_BYTE) bcnt <= bcnt + 1'b1;
        if (state == WR_BYTE && bcnt == 3'd7) cnt <= cnt - 1'b1;
        if ((state == ADDR_ACK || state == WR_ACK) && !ack) nack_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_multibyte.sv
// tb_i2c_master_multibyte: directed and randomized transfers against a behavioural I2C slave,
// with bus, rx and done scoreboards fed from a transaction-level model.
module tb_i2c_master_multibyte;
  localparam int CLK_DIV = 4;
  localparam int LEN_W = 4;
  localparam logic [6:0] SLV = 7'h2A;
  localparam int EV_START = 32'h1000;
  localparam int EV_STOP = 32'h2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_master_multibyte_if #(.LEN_W(LEN_W)) b();
  i2c_master_multibyte #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(b));

  logic s_sda_low = 1'b0;
  assign b.scl_i = !b.scl_oe;
  assign b.sda_i = !b.sda_oe && !s_sda_low;

  int tests = 0;
  int fails = 0;
  int bus_q[$];
  int rx_q[$];
  int done_q[$];
  logic [7:0] dq[$];
  logic [7:0] rd_src[$];
  int nack_at = 99;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic obs(input int v);
    if (bus_q.size() == 0) chk("bus_extra_event", v, -1);
    else chk("bus_event", v, bus_q.pop_front());
  endtask

  // Behavioural slave at SLV: decodes the bus on sampled line levels, ACKs its address,
  // ACKs writes except byte nack_at, and serves reads from rd_src.
  logic ps = 1'b1, pd = 1'b1, cs, cd;
  logic act = 1'b0, aph = 1'b0, match = 1'b0, rd = 1'b0, tx_on = 1'b0, mack = 1'b1;
  int nb = 0, widx = 0;
  logic [7:0] sr = 8'h00, ob = 8'h00;
  always @(negedge clk) begin
    cs = b.scl_i;
    cd = b.sda_i;
    if (!rst) begin
      act = 1'b0;
      s_sda_low = 1'b0;
    end else if (ps && cs && pd && !cd) begin
      act = 1'b1; aph = 1'b1; nb = 0; match = 1'b0; rd = 1'b0; tx_on = 1'b0; mack = 1'b1; widx = 0;
      s_sda_low = 1'b0;
      obs(EV_START);
    end else if (ps && cs && !pd && cd) begin
      act = 1'b0;
      s_sda_low = 1'b0;
      obs(EV_STOP);
    end else if (act && !ps && cs) begin
      if (nb < 8) begin
        sr = {sr[6:0], cd};
        nb++;
      end else begin
        obs({23'd0, sr, cd});
        mack = cd;
        nb = 0;
      end
    end else if (act && ps && !cs) begin
      if (nb == 8) begin
        tx_on = 1'b0;
        if (aph) begin
          match = sr[7:1] == SLV;
          rd = sr[0];
          aph = 1'b0;
          s_sda_low = match;
        end else if (!rd) begin
          s_sda_low = match && widx != nack_at;
          widx++;
        end else s_sda_low = 1'b0;
      end else begin
        if (nb == 0) begin
          tx_on = match && rd && !mack && rd_src.size() > 0;
          if (tx_on) ob = rd_src.pop_front();
        end
        s_sda_low = tx_on && !ob[7 - nb];
      end
    end
    ps = cs;
    pd = cd;
  end

  always @(negedge clk) begin
    if (rst && b.rx_valid) begin
      if (rx_q.size() == 0) chk("rx_extra", int'(b.rx_data), -1);
      else chk("rx_data", int'(b.rx_data), rx_q.pop_front());
    end
    if (rst && b.done) begin
      if (done_q.size() == 0) chk("done_extra", int'(b.nack_err), -1);
      else chk("nack_err", int'(b.nack_err), done_q.pop_front());
    end
  end

  task automatic fill(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
  endtask

  task automatic run_txn(input logic r, input logic [6:0] a, input int n, input int nk, input int hold);
    logic present, nacked, fin, held_ok, hold_test;
    int ehs, hs, cyc, dly;
    present = a == SLV;
    hold_test = hold > 0;
    nack_at = nk;
    rd_src.delete();
    if (r) foreach (dq[i]) rd_src.push_back(dq[i]);
    bus_q.push_back(EV_START);
    bus_q.push_back({23'd0, a, r, !present});
    nacked = !present;
    ehs = 0;
    if (present) begin
      for (int i = 0; i < n; i++) begin
        if (r) begin
          bus_q.push_back({23'd0, dq[i], i == n - 1});
          rx_q.push_back(int'(dq[i]));
        end else begin
          bus_q.push_back({23'd0, dq[i], i == nk});
          ehs++;
          if (i == nk) begin
            nacked = 1'b1;
            break;
          end
        end
      end
    end
    bus_q.push_back(EV_STOP);
    done_q.push_back(int'(nacked));
    @(posedge clk); #1;
    b.start = 1'b1; b.rw = r; b.addr = a; b.len = LEN_W'(n);
    @(posedge clk); #1;
    b.start = 1'b0; b.addr = 7'($urandom); b.rw = 1'($urandom); b.len = LEN_W'($urandom);
    hs = 0; cyc = 0; fin = 1'b0; dly = -1; held_ok = 1'b1;
    while (!fin && cyc < 20000) begin
      b.start = cyc == 20;
      if (b.tx_valid && !b.tx_ready) begin
        b.tx_valid = 1'b0;
        hs++;
      end
      if (b.tx_ready && !b.tx_valid) begin
        if (dly < 0) begin
          dly = hold > 0 ? hold : int'($urandom_range(0, 4));
          hold = 0;
        end
        if (dly == 0) begin
          b.tx_valid = 1'b1;
          b.tx_data = hs < dq.size() ? dq[hs] : 8'h00;
          dly = -1;
        end else begin
          dly--;
          held_ok &= b.scl_oe;
        end
      end
      fin = b.done;
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    b.start = 1'b0;
    chk("done_seen", int'(fin), 1);
    chk("tx_handshakes", hs, ehs);
    chk("idle_after_done", int'(b.busy), 0);
    if (hold_test) chk("scl_held_low", int'(held_ok), 1);
  endtask

  task automatic reset_mid();
    bus_q.push_back(EV_START);
    @(posedge clk); #1;
    b.start = 1'b1; b.rw = 1'b0; b.addr = SLV; b.len = LEN_W'(2);
    @(posedge clk); #1;
    b.start = 1'b0;
    repeat (69) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_scl_oe", int'(b.scl_oe), 0);
    chk("rst_mid_sda_oe", int'(b.sda_oe), 0);
    chk("rst_mid_busy", int'(b.busy), 0);
    chk("rst_mid_nack", int'(b.nack_err), 0);
    rst = 1'b1;
  endtask

  initial begin
    logic r;
    logic [6:0] a;
    int n, nk;
    b.start = 1'b0; b.rw = 1'b0; b.addr = '0; b.len = '0; b.tx_data = '0; b.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl_oe", int'(b.scl_oe), 0);
    chk("rst_sda_oe", int'(b.sda_oe), 0);
    chk("rst_busy", int'(b.busy), 0);
    chk("rst_done", int'(b.done), 0);
    chk("rst_rx_valid", int'(b.rx_valid), 0);
    chk("rst_tx_ready", int'(b.tx_ready), 0);
    chk("rst_nack_err", int'(b.nack_err), 0);
    chk("rst_rx_data", int'(b.rx_data), 0);
    rst = 1'b1;
    dq = '{8'hA5, 8'h3C};
    run_txn(1'b0, SLV, 2, 99, 0);
    dq = '{8'hCC, 8'h12, 8'hFF};
    run_txn(1'b1, SLV, 3, 99, 0);
    dq = '{8'h01, 8'h02};
    run_txn(1'b0, 7'h11, 2, 99, 0);
    dq.delete();
    run_txn(1'b0, SLV, 0, 99, 0);
    fill(3);
    run_txn(1'b0, SLV, 3, 99, 50);
    fill(3);
    run_txn(1'b0, SLV, 3, 1, 0);
    fill(15);
    run_txn(1'b1, SLV, 15, 99, 0);
    reset_mid();
    fill(2);
    run_txn(1'b0, SLV, 2, 99, 0);
    for (int k = 0; k < 12; k++) begin
      n = int'($urandom_range(0, 5));
      r = n == 0 ? 1'b0 : 1'($urandom);
      a = $urandom_range(0, 3) == 0 ? 7'($urandom) : SLV;
      nk = (!r && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 99;
      fill(n);
      run_txn(r, a, n, nk, 0);
    end
    repeat (10) @(posedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("rx_q_drained", rx_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_master_multibyte.md
Name: i2c_master_multibyte

Overview:
Parametrised I2C master for single-master buses. Runs multi-byte read and write transfers: START, 7-bit address + R/W, N data bytes with ACK/NACK, then STOP.
- Programmable SCL divider.
- Open-drain pad interface with separate output-enable and input pins.
- Per-byte valid/ready data handshake.
- Sits between a register/control FSM and the pad ring; replaces the fixed-rate, single-byte master.

Parameters:
CLK_DIV, 25, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV clk cycles); legal range >= 2.
LEN_W, 4, width of the byte-count field; max transfer is 2^LEN_W-1 bytes.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
start  input  1  request a transfer; accepted only when busy=0.
rw  input  1  0=write, 1=read; latched on accept.
addr  input  7  target address; latched on accept.
len  input  LEN_W  byte count; latched on accept; 0 = address-only probe.
tx_data  input  8  next write byte.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  master is waiting for a write byte.
rx_data  output  8  last received byte.
rx_valid  output  1  one-cycle pulse; rx_data is updated.
busy  output  1  transfer in progress.
done  output  1  one-cycle pulse when STOP completes.
nack_err  output  1  transfer ended because of a NACK.
scl_i  input  1  SCL pad input.
scl_oe  output  1  1 = pull SCL low.
sda_i  input  1  SDA pad input.
sda_oe  output  1  1 = pull SDA low.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; the quarter counter and the byte counter clear.
  - scl_oe, sda_oe, busy, done, rx_valid, tx_ready, nack_err and rx_data all go to 0.
  - Mid-transfer reset releases the bus immediately; no STOP is generated.
- Timing tick: asserted every CLK_DIV clk cycles while busy. A bit spans quarters Q0..Q3:
  - Q0-Q1: SCL low; SDA changes at the start of Q0.
  - Q2-Q3: SCL released.
  - Master samples sda_i at the end of Q2.
- States: IDLE, START, ADDR, ADDR_ACK, LOAD, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
- IDLE:
  - start=1 latches addr, rw and len, clears nack_err, sets busy next cycle, goes to START.
  - start while busy=1 is ignored.
- START (4 quarters): SDA and SCL released for Q0-Q1; SDA low at Q2 while SCL high; SCL low at the end of Q3.
- ADDR: shifts {addr,rw}, MSB first, 8 bits.
- ADDR_ACK: releases SDA and samples ACK.
  - sda_i=1 -> nack_err=1, go to STOP.
  - ACK with len=0 -> STOP.
  - ACK with rw=0 -> LOAD.
  - ACK with rw=1 -> RD_BYTE.
- LOAD:
  - tx_ready=1 and SCL held low; the master stretches indefinitely until tx_valid=1.
  - Byte captured on the cycle tx_valid&&tx_ready; tx_ready drops next cycle; go to WR_BYTE.
- WR_BYTE: shifts 8 bits, MSB first.
- WR_ACK: samples ACK.
  - NACK -> nack_err=1, STOP, even if bytes remain.
  - ACK with bytes remaining -> LOAD, else STOP.
- RD_BYTE:
  - SDA released; 8 bits shifted in MSB first.
  - After the 8th sample, rx_data updates and rx_valid pulses for 1 cycle.
- RD_ACK: master drives ACK (sda_oe=1) if bytes remain, NACK (released) on the last byte; then RD_BYTE or STOP.
- STOP (4 quarters): SCL low + SDA low at Q0-Q1; SCL released at Q2; SDA released at Q3.
  - Exit: done pulses 1 cycle, busy=0, return to IDLE.
- nack_err holds until the next accepted start.
- The byte counter decrements once per completed data byte.

Optional Feature:
Macro I2C_MASTER_CLK_STRETCH_EN.
- Defined: after releasing SCL, the quarter counter freezes until scl_i=1 (slave clock stretching). Sampling and Q2 timing restart from the first cycle scl_i is seen high.
- Undefined: scl_i is ignored and timing is free-running. The port remains present but unused.

Test Plan:
- Write 2 bytes (0xA5, 0x3C) to addr 0x2A, slave ACKs all -> bus shows 0x54, A5, 3C, each followed by ACK, then STOP; tx_ready handshakes twice; done=1, nack_err=0.
- Read 3 bytes from addr 0x2A, slave returns 0xCC, 0x12, 0xFF -> rx_valid pulses 3 times with those values; master ACK, ACK, NACK; then STOP.
- Address 0x11 with no slave (SDA stays high) -> nack_err=1 after the 9th SCL; STOP follows; no tx_ready asserted; done pulses.
- len=0 probe to 0x2A -> START, 0x54, ACK, STOP only; done pulses; rx_valid never pulses.
- Write with tx_valid withheld 50 cycles -> SCL held low throughout; transfer resumes correctly. With stretch enabled and slave holding SCL low 30 cycles -> the bit is extended by 30 cycles and data is intact.
- rst=0 during the 4th address bit -> next cycle scl_oe=0, sda_oe=0, busy=0; a new start is then accepted normally.
